// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one multiplier between NUM_REQ requesters.
// Latches the winner's operands, runs the enable/ready handshake and returns the product.
module mult_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                     sysclk,
  input  logic                     nreset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] op_a,
  input  logic [NUM_REQ*WIDTH-1:0] op_b,
  output logic [NUM_REQ-1:0]       ack,
  output logic [NUM_REQ-1:0]       done,
  output logic [NUM_REQ-1:0]       err,
  output logic [WIDTH-1:0]         result,
  output logic                     busy,
  output logic                     mul_enable,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic [WIDTH-1:0]         mul_result,
  input  logic                     mul_ready,
  output logic [2:0]               state_dbg
);

  // Requester handshake: req is held high until that requester's done or err
  // pulse; ack marks the cycle after which its operands may change.
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4
  } state_t;

  state_t               state;
  logic [IW-1:0]        rr;
  logic [IW-1:0]        win;
  logic [NUM_REQ-1:0]   gnt_oh;
  logic [7:0]           cnt;

  assign state_dbg = state;

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    win = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(rr) + k) % NUM_REQ]) win = IW'((int'(rr) + k) % NUM_REQ);
    end
  end

  always_ff @(posedge sysclk or negedge nreset) begin
    if (!nreset) begin
      state      <= S_IDLE;
      rr         <= IW'(NUM_REQ - 1);
      gnt_oh     <= '0;
      cnt        <= '0;
      ack        <= '0;
      done       <= '0;
      err        <= '0;
      result     <= '0;
      busy       <= 1'b0;
      mul_enable <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
    end else begin
      ack  <= '0;
      done <= '0;
      err  <= '0;
      case (state)
        S_IDLE: begin
          if (|req && mul_ready) begin
            state      <= S_START;
            rr         <= win;
            gnt_oh     <= NUM_REQ'(1) << win;
            ack        <= NUM_REQ'(1) << win;
            mul_a      <= op_a[win*WIDTH +: WIDTH];
            mul_b      <= op_b[win*WIDTH +: WIDTH];
            mul_enable <= 1'b1;
            busy       <= 1'b1;
            cnt        <= '0;
          end
        end
        S_START: begin
          if (!mul_ready) begin
            state      <= S_WAIT;
            mul_enable <= 1'b0;
            cnt        <= '0;
          end else if (cnt == TO_LAST) begin
            state      <= S_ABORT;
            mul_enable <= 1'b0;
            err        <= gnt_oh;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_WAIT: begin
          if (mul_ready) begin
            state  <= S_DONE;
            result <= mul_result;
            done   <= gnt_oh;
          end else if (cnt == TO_LAST) begin
            state <= S_ABORT;
            err   <= gnt_oh;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DONE, S_ABORT: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          mul_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: behavioural multiplier, requester driver, round-robin
// reference model and result scoreboard.
module tb_mult_arbiter;

  localparam int NR = 2;
  localparam int W  = 32;
  localparam int TO = 20;

  logic            clk;
  logic            nreset;
  logic [NR-1:0]   req;
  logic [NR*W-1:0] op_a, op_b;
  logic [NR-1:0]   ack, done, err;
  logic [W-1:0]    result;
  logic            busy, mul_enable;
  logic [W-1:0]    mul_a, mul_b, mul_result;
  logic            mul_ready;
  logic [2:0]      state_dbg;

  mult_arbiter #(.NUM_REQ(NR), .WIDTH(W), .TIMEOUT(TO)) dut (
    .sysclk(clk), .nreset(nreset), .req(req), .op_a(op_a), .op_b(op_b),
    .ack(ack), .done(done), .err(err), .result(result), .busy(busy),
    .mul_enable(mul_enable), .mul_a(mul_a), .mul_b(mul_b),
    .mul_result(mul_result), .mul_ready(mul_ready), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // ---------------- bench state ----------------
  int checks = 0;
  int failures = 0;

  int            m_rr;
  logic [NR-1:0] last_req;
  logic [NR*W-1:0] last_a, last_b;
  logic [W-1:0]  prev_mul_a, prev_mul_b;
  logic [W-1:0]  exp_q[$];
  int            exp_idx_q[$];
  bit            expect_abort;
  int            n_ack, n_done, n_err;
  logic [W-1:0]  last_done_res;
  int            grant_log[$];
  int            done_idx_log[$];
  logic [W-1:0]  done_res_log[$];

  bit            ack_seen[NR], done_seen[NR], err_seen[NR];
  bit            pend_valid[NR];
  logic [W-1:0]  pend_a[NR], pend_b[NR];
  int            mul_mode;  // 0 normal, 1 never drops ready, 2 never returns ready

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  function automatic logic [W-1:0] model_product(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] full;
    full = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return full[W-1:0];
  endfunction

  // ---------------- behavioural multiplier ----------------
  initial begin
    int m_state, dly;
    mul_ready  = 1'b1;
    mul_result = '0;
    m_state    = 0;
    dly        = 0;
    forever begin
      @(posedge clk);
      #1;
      case (m_state)
        0: if (mul_mode != 1 && mul_enable && mul_ready) begin
             dly = $urandom_range(0, 2);
             m_state = 1;
           end
        1: if (dly == 0) begin
             mul_ready = 1'b0;
             dly = $urandom_range(1, 4);
             m_state = 2;
           end else dly--;
        default: if (mul_mode != 2) begin
             if (dly == 0) begin
               mul_result = model_product(mul_a, mul_b);
               mul_ready  = 1'b1;
               m_state    = 0;
             end else dly--;
           end
      endcase
    end
  end

  // ---------------- requester driver ----------------
  initial begin
    req  = '0;
    op_a = '0;
    op_b = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!nreset) begin
        req = '0;
      end else begin
        for (int i = 0; i < NR; i++) begin
          if (req[i] && (done_seen[i] || err_seen[i])) begin
            req[i] = 1'b0;
            done_seen[i] = 1'b0;
            err_seen[i]  = 1'b0;
          end else if (!req[i] && pend_valid[i]) begin
            req[i] = 1'b1;
            op_a[i*W +: W] = pend_a[i];
            op_b[i*W +: W] = pend_b[i];
            pend_valid[i] = 1'b0;
          end
          if (ack_seen[i]) begin
            ack_seen[i] = 1'b0;
            op_a[i*W +: W] = $urandom;
            op_b[i*W +: W] = $urandom;
          end
        end
      end
    end
  end

  // ---------------- monitor, reference model and scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (nreset) begin
        if (|{ack, done, err}) check("one_hot_pulse", 64'($countones({ack, done, err})), 64'd1);
        if (!(|ack)) begin
          check("mul_a_hold", mul_a, prev_mul_a);
          check("mul_b_hold", mul_b, prev_mul_b);
        end
        for (int i = 0; i < NR; i++) begin
          if (ack[i]) begin
            int w;
            w = -1;
            for (int k = 1; k <= NR; k++)
              if (w < 0 && last_req[(m_rr + k) % NR]) w = (m_rr + k) % NR;
            check("grant_idx", i, w);
            check("ack_mul_enable", mul_enable, 1'b1);
            check("ack_busy", busy, 1'b1);
            check("latch_a", mul_a, last_a[i*W +: W]);
            check("latch_b", mul_b, last_b[i*W +: W]);
            m_rr = i;
            exp_q.push_back(model_product(last_a[i*W +: W], last_b[i*W +: W]));
            exp_idx_q.push_back(i);
            grant_log.push_back(i);
            ack_seen[i] = 1'b1;
            n_ack++;
          end
          if (done[i] || err[i]) begin
            if (exp_q.size() == 0) begin
              check("pulse_without_grant", 1, 0);
            end else begin
              logic [W-1:0] e;
              int ei;
              e  = exp_q.pop_front();
              ei = exp_idx_q.pop_front();
              check(done[i] ? "done_idx" : "err_idx", i, ei);
              if (done[i]) begin
                check("done_unexpected", expect_abort, 1'b0);
                check("result", result, e);
                done_seen[i] = 1'b1;
                last_done_res = result;
                done_idx_log.push_back(i);
                done_res_log.push_back(result);
                n_done++;
              end else begin
                check("err_unexpected", expect_abort, 1'b1);
                check("err_mul_enable", mul_enable, 1'b0);
                err_seen[i] = 1'b1;
                n_err++;
              end
            end
          end
        end
      end
      prev_mul_a = mul_a;
      prev_mul_b = mul_b;
      last_req   = req;
      last_a     = op_a;
      last_b     = op_b;
    end
  end

  // ---------------- sequence helpers ----------------
  task automatic clear_model();
    exp_q.delete();
    exp_idx_q.delete();
    grant_log.delete();
    done_idx_log.delete();
    done_res_log.delete();
    m_rr = NR - 1;
    expect_abort = 1'b0;
    for (int i = 0; i < NR; i++) begin
      ack_seen[i] = 0; done_seen[i] = 0; err_seen[i] = 0; pend_valid[i] = 0;
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_pulses", {ack, done, err}, '0);
    check("rst_busy_en", {busy, mul_enable}, '0);
    check("rst_result", result, '0);
    check("rst_mul_a", mul_a, '0);
    check("rst_mul_b", mul_b, '0);
  endtask

  task automatic apply_reset();
    nreset = 1'b0;
    #1;
    check_reset_outputs();
    repeat (3) @(posedge clk);
    clear_model();
    @(posedge clk);
    #3;
    nreset = 1'b1;
  endtask

  task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    pend_a[i] = a;
    pend_b[i] = b;
    pend_valid[i] = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    bit pend_any;
    n = 0;
    forever begin
      tick();
      pend_any = 0;
      for (int i = 0; i < NR; i++) pend_any |= pend_valid[i];
      if (!pend_any && req == '0 && !busy && exp_q.size() == 0) break;
      if (++n >= budget) begin
        check({tag, "_idle_timeout"}, 0, 1);
        break;
      end
    end
  endtask

  task automatic run_single(input string tag, input int i, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] exp_res);
    int n0;
    n0 = n_done;
    issue(i, a, b);
    wait_idle(tag, 200);
    check({tag, "_done_count"}, n_done, n0 + 1);
    check(tag, last_done_res, exp_res);
  endtask

  task automatic run_timeout(input string tag, input int mode, input int i);
    int n0, e0, d0, k;
    mul_mode = mode;
    expect_abort = 1'b1;
    n0 = n_ack; e0 = n_err; d0 = n_done;
    issue(i, $urandom, $urandom);
    k = 0;
    while (n_ack == n0 && k < 100) begin tick(); k++; end
    check({tag, "_granted"}, n_ack, n0 + 1);
    k = 0;
    while (n_err == e0 && k < 3 * TO) begin tick(); k++; end
    check({tag, "_err_count"}, n_err, e0 + 1);
    if (mode == 1) check({tag, "_cycles"}, k, TO);
    check({tag, "_no_done"}, n_done, d0);
    mul_mode = 0;
    tick();
    expect_abort = 1'b0;
    wait_idle(tag, 100);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int issued[NR];
    int k;
    int nd;
    mul_mode = 0;
    n_ack = 0; n_done = 0; n_err = 0;
    last_done_res = '0;
    clear_model();
    nreset = 1'b1;
    #3;
    apply_reset();
    repeat (2) tick();
    check_reset_outputs();

    // Single requester, then the documented operand corner cases.
    run_single("basic_12x4", 0, 32'd12, 32'd4, 32'd48);
    run_single("trunc_zero", 0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
    run_single("trunc_ones", 1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
    run_single("zero_op", 1, 32'd0, 32'hDEAD_BEEF, 32'd0);

    // Simultaneous requests right after reset, then both keep re-requesting.
    apply_reset();
    tick();
    issue(0, 32'd3, 32'd5);
    issue(1, 32'd7, 32'd6);
    issued[0] = 1; issued[1] = 1;
    k = 0;
    while ((issued[0] < 4 || issued[1] < 4 || busy || req != '0) && k < 400) begin
      tick();
      k++;
      for (int i = 0; i < NR; i++)
        if (!req[i] && !pend_valid[i] && issued[i] < 4) begin
          issue(i, $urandom, $urandom);
          issued[i]++;
        end
    end
    wait_idle("fair", 100);
    if (done_res_log.size() < 2) begin
      check("simul_count", done_res_log.size(), 2);
    end else begin
      check("simul_first_idx", done_idx_log[0], 0);
      check("simul_first_res", done_res_log[0], 32'd15);
      check("simul_second_idx", done_idx_log[1], 1);
      check("simul_second_res", done_res_log[1], 32'd42);
    end
    if (grant_log.size() != 8) check("fair_count", grant_log.size(), 8);
    else for (int i = 0; i < 8; i++) check("fair_alternate", grant_log[i], i % 2);

    // Random traffic with mixed operand classes.
    for (int c = 0; c < 600; c++) begin
      tick();
      for (int i = 0; i < NR; i++)
        if (!req[i] && !pend_valid[i] && $urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 3))
            0: issue(i, $urandom_range(0, 255), $urandom_range(0, 255));
            1: issue(i, 32'hFFFF_FFFF, $urandom);
            default: issue(i, $urandom, $urandom);
          endcase
        end
    end
    wait_idle("random", 200);

    // Multiplier never leaves ready, then never returns ready.
    run_timeout("to_start", 1, 1);
    run_single("after_to_start", 0, 32'd9, 32'd9, 32'd81);
    run_timeout("to_wait", 2, 0);
    run_single("after_to_wait", 1, 32'd100, 32'd3, 32'd300);

    // Reset while the multiplier is busy.
    k = n_ack;
    issue(0, $urandom, $urandom);
    for (int c = 0; c < 50 && n_ack == k; c++) tick();
    for (int c = 0; c < 50 && mul_enable; c++) tick();
    check("rst_wait_reached", {busy, mul_enable}, 2'b10);
    nd = n_done;
    nreset = 1'b0;
    #1;
    check_reset_outputs();
    repeat (3) @(posedge clk);
    clear_model();
    @(posedge clk);
    #3;
    nreset = 1'b1;
    repeat (6) tick();
    check("rst_no_done", n_done, nd);
    run_single("after_reset_2x11", 0, 32'd2, 32'd11, 32'd22);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
